pp_error_monitor: RTL and testbench
===================================

# pp_error_monitor

Sequential consumer of the two-row output (`pp1`, `pp2`) of the partial-product reduction tree. For each sample it forms the approximate product, compares it with the exact product of the same operands, and accumulates error statistics over a batch of 2^LOG2_SAMPLES samples. These statistics are error-distance sum, maximum and error count, plus squared-error sum when `PP_ERR_SQ_EN` is defined. It sits at the output of the approximate multiplier in the compressor-configuration evaluation flow and produces the per-configuration labels used for training.

## Interface
- `Bitwidth`, default 8: operand width; `pp1`/`pp2`/products are 2*Bitwidth wide.
- `LOG2_SAMPLES`, default 8: log2 of batch size N.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a batch; honoured only in IDLE.
- `in_valid` in 1: sample valid.
- `in_ready` out 1: sample accepted when `in_valid && in_ready` at a rising edge.
- `a`, `b` in Bitwidth: unsigned operands.
- `pp1`, `pp2` in 2*Bitwidth: reduction-tree rows for `a*b`.
- `stat_valid` out 1: batch statistics valid.
- `stat_ready` in 1: statistics consumed on `stat_valid && stat_ready`.
- `sum_ed` out 2*Bitwidth+LOG2_SAMPLES: sum of error distances.
- `max_ed` out 2*Bitwidth: maximum error distance.
- `err_cnt` out LOG2_SAMPLES+1: number of samples with ED ≠ 0.
- `sum_sq_ed` out 4*Bitwidth+LOG2_SAMPLES: sum of ED²; present only with `PP_ERR_SQ_EN`.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states:
  - IDLE → RUN on `start`. Entering RUN clears all statistics and the sample counter.
  - RUN → DRAIN on the edge that accepts sample N-1.
  - DRAIN → REPORT after one cycle, once the pipeline is empty.
  - REPORT → IDLE on `stat_valid && stat_ready`.
- `in_ready` = (state == RUN). `stat_valid` = (state == REPORT).
- Stage 1 registers the following on each accept, and sets `s1_v`:
  - approx = (pp1 + (pp2 << 1)) mod 2^(2*Bitwidth);
  - exact = a*b, unsigned, 2*Bitwidth bits.
- Stage 2 runs when `s1_v` is set and computes ED = |exact − approx| (2*Bitwidth bits, unsigned). It then updates the statistics:
  - `sum_ed` += ED;
  - `max_ed` = max(`max_ed`, ED);
  - `err_cnt` += (ED ≠ 0);
  - `sum_sq_ed` += ED².
- Accumulator widths are sized so that a full batch never overflows. No saturation logic is needed.
- Statistic outputs hold their values after REPORT until the next `start` clears them.
- `start` outside IDLE is ignored.
- `in_valid` outside RUN is ignored; no sample is consumed.
- Gaps in `in_valid` during RUN stall the count without affecting statistics.
- `rst` at any time:
  - state = IDLE;
  - all statistics, counter and `s1_v` = 0;
  - `in_ready`, `stat_valid`, `busy` = 0.

## Timing
- Reset values: every output is 0.
- `in_ready` rises the cycle after the `start` edge.
- Statistics reflect a sample 2 edges after its accept edge.
- `stat_valid` rises 2 cycles after the edge accepting the last sample. `in_ready` is low from the cycle after that edge.
- `stat_valid` stays high and all statistics stay stable while `stat_ready` = 0.
- Throughput is one sample per cycle.
- The pipeline holds no backpressure state; stage 2 always completes.

## Configuration
- `PP_ERR_SQ_EN` defined: the `sum_sq_ed` port, the squarer and its accumulator are compiled in.
- `PP_ERR_SQ_EN` undefined: the port and logic are absent. All other behaviour is identical.

## Test plan
Use Bitwidth=8, LOG2_SAMPLES=2 (N=4) unless stated.
- Exact batch: 4× (a=3, b=5, pp1=15, pp2=0) back-to-back → `stat_valid` 2 cycles after the 4th accept; `sum_ed`=0, `max_ed`=0, `err_cnt`=0, `sum_sq_ed`=0.
- Error mix: samples with ED 4, 0, 7, 1 (e.g. a=b=10, pp1=96, pp2=0 gives ED=4) → `sum_ed`=12, `max_ed`=7, `err_cnt`=3, `sum_sq_ed`=66.
- Wrap-around: a=b=0, pp1=0xFFFF, pp2=0x0001 → approx=1, ED=1. Repeated 4× → `sum_ed`=4, `max_ed`=1, `err_cnt`=4.
- Backpressure: hold `stat_ready`=0 for 5 cycles in REPORT, pulse `start` and `in_valid` → outputs stable, `in_ready`=0, no new batch. Then `stat_ready`=1 → IDLE next cycle, `busy`=0.
- Reset mid-run: reset after 2 accepted samples → all outputs 0 on the next cycle. A following `start` plus 4 exact samples yields all-zero statistics with `err_cnt`=0.
- Gapped input: 4 samples with 3 idle cycles between each, ED=2 each → `sum_ed`=8, `err_cnt`=4. `stat_valid` asserts exactly 2 cycles after the last accept.

Source files
------------

// File: rtl/pp_error_monitor.sv
// pp_error_monitor: batch error statistics for approximate multiplier rows.
// Optional squared-error accumulator: define PP_ERR_SQ_EN.
module pp_error_monitor #(
  parameter int Bitwidth     = 8,
  parameter int LOG2_SAMPLES = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [Bitwidth-1:0]              a,
  input  logic [Bitwidth-1:0]              b,
  input  logic [2*Bitwidth-1:0]            pp1,
  input  logic [2*Bitwidth-1:0]            pp2,
  output logic                             stat_valid,
  input  logic                             stat_ready,
  output logic [2*Bitwidth+LOG2_SAMPLES-1:0] sum_ed,
  output logic [2*Bitwidth-1:0]            max_ed,
  output logic [LOG2_SAMPLES:0]            err_cnt,
  output logic                             busy
`ifdef PP_ERR_SQ_EN
  ,
  output logic [4*Bitwidth+LOG2_SAMPLES-1:0] sum_sq_ed
`endif
);

  localparam int PW = 2 * Bitwidth;
  localparam int SW = PW + LOG2_SAMPLES;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;
  localparam logic [1:0] REPORT = 2'd3;

  logic [1:0]              state;
  logic [LOG2_SAMPLES-1:0] cnt;
  logic                    accept;
  logic                    last;
  logic                    clear;

  logic                    s1_v;
  logic [PW-1:0]           s1_approx;
  logic [PW-1:0]           s1_exact;

  logic [PW-1:0]           approx;
  logic [PW-1:0]           exact;
  logic [PW-1:0]           ed;

  assign accept = in_valid && (state == RUN);
  assign last   = accept && (cnt == '1);
  assign clear  = start && (state == IDLE);

  assign in_ready   = (state == RUN);
  assign stat_valid = (state == REPORT);
  assign busy       = (state != IDLE);

  // approx drops the carry out of the 2*Bitwidth sum
  assign approx = pp1 + {pp2[PW-2:0], 1'b0};
  assign exact  = {{Bitwidth{1'b0}}, a}
                * {{Bitwidth{1'b0}}, b};

  assign ed = (s1_exact >= s1_approx)
            ? (s1_exact - s1_approx)
            : (s1_approx - s1_exact);

  // batch control: run N accepts, drain stage 2, hold report
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      unique case (1'b1)
        (state == IDLE):   if (start) state <= RUN;
        (state == RUN):    if (last) state <= DRAIN;
        (state == DRAIN):  state <= REPORT;
        (state == REPORT): if (stat_ready) state <= IDLE;
        default:           state <= IDLE;
      endcase
    end
  end

  // stage 1: register approx/exact products and count accepts
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      s1_v      <= 1'b0;
      s1_approx <= '0;
      s1_exact  <= '0;
    end else begin
      s1_v <= accept;
      if (accept) begin
        s1_approx <= approx;
        s1_exact  <= exact;
        cnt       <= cnt + 1'b1;
      end
      if (clear) cnt <= '0;
    end
  end

  // stage 2: fold one error distance into the batch statistics
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sum_ed  <= '0;
      max_ed  <= '0;
      err_cnt <= '0;
    end else if (s1_v) begin
      sum_ed <= sum_ed + {{LOG2_SAMPLES{1'b0}}, ed};
      if (ed > max_ed) max_ed <= ed;
      if (ed != '0) err_cnt <= err_cnt + 1'b1;
    end
  end

`ifdef PP_ERR_SQ_EN
  logic [2*PW-1:0] ed_sq;

  assign ed_sq = {{PW{1'b0}}, ed} * {{PW{1'b0}}, ed};

  // stage 2: squared error accumulator
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sum_sq_ed <= '0;
    end else if (s1_v) begin
      sum_sq_ed <= sum_sq_ed + {{LOG2_SAMPLES{1'b0}}, ed_sq};
    end
  end
`endif

  logic unused_sw;
  assign unused_sw = (SW == 0);

endmodule

// File: tb/tb_pp_error_monitor.sv
// tb_pp_error_monitor: directed and random batches against a
// batch-level reference model (N=4, Bitwidth=8).
module tb_pp_error_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic [15:0] pp1 = '0;
  logic [15:0] pp2 = '0;
  logic        stat_valid;
  logic        stat_ready = 1'b0;
  logic [17:0] sum_ed;
  logic [15:0] max_ed;
  logic [2:0]  err_cnt;
  logic        busy;
`ifdef PP_ERR_SQ_EN
  logic [33:0] sum_sq_ed;
`endif

  int checks = 0;
  int errors = 0;

  int q_a[$];
  int q_b[$];
  int q_p1[$];
  int q_p2[$];
  int q_gap[$];

  pp_error_monitor #(
    .Bitwidth(8),
    .LOG2_SAMPLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .pp1(pp1),
    .pp2(pp2),
    .stat_valid(stat_valid),
    .stat_ready(stat_ready),
    .sum_ed(sum_ed),
    .max_ed(max_ed),
    .err_cnt(err_cnt),
    .busy(busy)
`ifdef PP_ERR_SQ_EN
    ,
    .sum_sq_ed(sum_sq_ed)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int ai, input int bi,
                      input int p1, input int p2,
                      input int gap);
    q_a.push_back(ai);
    q_b.push_back(bi);
    q_p1.push_back(p1);
    q_p2.push_back(p2);
    q_gap.push_back(gap);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_rdy"}, 64'(in_ready), 64'd0);
    check({tag, "_sv"}, 64'(stat_valid), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_sum"}, 64'(sum_ed), 64'd0);
    check({tag, "_max"}, 64'(max_ed), 64'd0);
    check({tag, "_cnt"}, 64'(err_cnt), 64'd0);
`ifdef PP_ERR_SQ_EN
    check({tag, "_sq"}, 64'(sum_sq_ed), 64'd0);
`endif
  endtask

  // feed the queued samples as one batch and check the report
  task automatic run_batch(input string tag, input int bp);
    longint es = 0;
    longint em = 0;
    longint ec = 0;
    longint esq = 0;
    int n;
    for (int i = 0; i < q_a.size(); i++) begin
      longint ex = longint'(q_a[i]) * q_b[i];
      longint ap = (longint'(q_p1[i]) + 2 * q_p2[i]) % 65536;
      longint ed = (ex > ap) ? ex - ap : ap - ex;
      es += ed;
      if (ed > em) em = ed;
      if (ed != 0) ec++;
      esq += ed * ed;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_rdy_rise"}, 64'(in_ready), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    for (int i = 0; i < q_a.size(); i++) begin
      a = 8'(q_a[i]);
      b = 8'(q_b[i]);
      pp1 = 16'(q_p1[i]);
      pp2 = 16'(q_p2[i]);
      in_valid = 1'b1;
      check({tag, "_rdy_in"}, 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      if (i < q_a.size() - 1)
        for (int g = 0; g < q_gap[i]; g++) tick();
    end
    check({tag, "_rdy_fall"}, 64'(in_ready), 64'd0);
    check({tag, "_sv_early"}, 64'(stat_valid), 64'd0);
    tick();
    n = 0;
    while (!stat_valid && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_sv_lat"}, 64'(n), 64'd0);
    check({tag, "_sum"}, 64'(sum_ed), 64'(es));
    check({tag, "_max"}, 64'(max_ed), 64'(em));
    check({tag, "_cnt"}, 64'(err_cnt), 64'(ec));
`ifdef PP_ERR_SQ_EN
    check({tag, "_sq"}, 64'(sum_sq_ed), 64'(esq));
`endif
    if (bp > 0) begin
      for (int i = 0; i < bp; i++) begin
        start = 1'b1;
        in_valid = 1'b1;
        tick();
      end
      start = 1'b0;
      in_valid = 1'b0;
      check({tag, "_bp_sv"}, 64'(stat_valid), 64'd1);
      check({tag, "_bp_rdy"}, 64'(in_ready), 64'd0);
      check({tag, "_bp_sum"}, 64'(sum_ed), 64'(es));
      check({tag, "_bp_max"}, 64'(max_ed), 64'(em));
      check({tag, "_bp_cnt"}, 64'(err_cnt), 64'(ec));
    end
    stat_ready = 1'b1;
    tick();
    stat_ready = 1'b0;
    check({tag, "_idle_sv"}, 64'(stat_valid), 64'd0);
    check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    tick();
    check({tag, "_hold_sum"}, 64'(sum_ed), 64'(es));
    check({tag, "_hold_cnt"}, 64'(err_cnt), 64'(ec));
    q_a.delete();
    q_b.delete();
    q_p1.delete();
    q_p2.delete();
    q_gap.delete();
  endtask

  // random sample: exact, small error, raw random, or large offset
  task automatic push_rand;
    int ai = int'($urandom_range(0, 255));
    int bi = int'($urandom_range(0, 255));
    int p2 = int'($urandom_range(0, 65535));
    int ex = ai * bi;
    int d;
    int p1;
    case ($urandom_range(0, 3))
      0: d = 0;
      1: d = int'($urandom_range(0, 16)) - 8;
      2: d = int'($urandom_range(0, 65535));
      default: d = int'($urandom_range(0, 8)) * 4096 + 1;
    endcase
    p1 = (ex + d - 2 * p2 + 4 * 65536) % 65536;
    push(ai, bi, p1, p2, int'($urandom_range(0, 2)));
  endtask

  initial begin
    repeat (2) tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();
    chk_zero("post_reset");

    for (int i = 0; i < 4; i++) push(3, 5, 15, 0, 0);
    run_batch("exact", 0);

    push(10, 10, 96, 0, 0);
    push(3, 5, 15, 0, 0);
    push(2, 4, 15, 0, 0);
    push(1, 1, 0, 0, 0);
    run_batch("mix", 0);

    for (int i = 0; i < 4; i++) push(0, 0, 16'hFFFF, 1, 0);
    run_batch("wrap", 0);

    push(10, 10, 96, 0, 0);
    push(2, 4, 15, 0, 0);
    push(1, 1, 0, 0, 0);
    push(9, 9, 80, 0, 0);
    run_batch("bp", 5);

    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a = 8'd2;
      b = 8'd4;
      pp1 = 16'd15;
      pp2 = 16'd0;
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero("midrst");
    for (int i = 0; i < 4; i++) push(3, 5, 15, 0, 0);
    run_batch("after_rst", 0);

    for (int i = 0; i < 4; i++) push(4, 4, 14, 0, 3);
    run_batch("gap", 0);

    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 4; i++) push_rand();
      run_batch($sformatf("rnd%0d", k), int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
